// File: rtl/adc_spi_seq_pkg.sv
// -----------------------------------------------------------------------------
// adc_spi_seq_pkg
// Shared definitions for the ADC SPI command sequencer:
//   - seq_state_e  : sequencer FSM states
//   - WORD_W_DEF   : default command word width
//   - DEF_TABLE    : power-on contents of the command table (entries 0..3)
//   - def_entry()  : default value for any table index (0 beyond entry 3)
// -----------------------------------------------------------------------------
package adc_spi_seq_pkg;

    localparam int WORD_W_DEF  = 16;
    localparam int DEF_ENTRIES = 4;

    // Packed so that DEF_TABLE[0] is the first word sent after reset.
    localparam logic [DEF_ENTRIES-1:0][15:0] DEF_TABLE = {
        16'h0400, 16'h0302, 16'h0201, 16'h0100
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } seq_state_e;

    function automatic logic [15:0] def_entry(input int unsigned idx);
        if (idx < DEF_ENTRIES) begin
            return DEF_TABLE[idx[1:0]];
        end
        return 16'h0000;
    endfunction

endpackage

// File: rtl/adc_spi_seq_table.sv
// -----------------------------------------------------------------------------
// adc_spi_seq_table
// Command word table: register array that resets to the package defaults,
// one synchronous write port and one combinational read port.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   we, waddr, wdata : write strobe / index / data (applied on rising aclk)
//   raddr, rdata  : combinational read
// -----------------------------------------------------------------------------
module adc_spi_seq_table
    import adc_spi_seq_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WORD_W'(def_entry(unsigned'(i)));
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // DEPTH is a power of two, so every raddr value is a valid entry.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/adc_spi_cmd_seq.sv
// -----------------------------------------------------------------------------
// adc_spi_cmd_seq
// Plays a table of SPI command words to a downstream shifter over an
// AXI-Stream style handshake, with a fixed idle gap between words.
// Optional feature macro: ADC_SPI_SEQ_AUTOSTART_EN -- when defined, one
// full-length (DEPTH words) sequence launches on the first aclk after reset.
// Ports:
//   aclk, aresetn       : clock, asynchronous active-low reset
//   start               : one-cycle launch pulse (ignored while busy)
//   cfg_we/addr/wdata   : table write port (ignored while busy)
//   cfg_len             : words per sequence, 0 or >DEPTH means DEPTH
//   m_tdata/m_tvalid    : command word out, m_tready from the shifter
//   busy                : sequence in progress
//   done                : one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module adc_spi_cmd_seq
    import adc_spi_seq_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int DEPTH   = 4,
    parameter int GAP_CYC = 10
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     start,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [WORD_W-1:0]        cfg_wdata,
    input  logic [$clog2(DEPTH):0]   cfg_len,
    output logic [WORD_W-1:0]        m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP_CYC + 2);
    localparam logic [AW:0] LEN_MAX = (AW + 1)'(DEPTH);

    seq_state_e        state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [AW:0]       len_q, len_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [WORD_W-1:0] rd_word;
    logic              start_go;
    logic [AW:0]       len_req;
    logic [AW:0]       len_sat;
    logic              last_word;
    logic              tbl_we;

`ifdef ADC_SPI_SEQ_AUTOSTART_EN
    // Set while in reset, so it acts as a start pulse on the first edge after
    // release and then clears for good.
    logic auto_q;
    logic auto_d;

    assign auto_d = 1'b0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            auto_q <= 1'b1;
        end else begin
            auto_q <= auto_d;
        end
    end

    assign start_go = start | auto_q;
    assign len_req  = auto_q ? LEN_MAX : cfg_len;
`else
    assign start_go = start;
    assign len_req  = cfg_len;
`endif

    assign len_sat   = ((len_req == '0) || (len_req > LEN_MAX)) ? LEN_MAX : len_req;
    assign last_word = ({1'b0, idx_q} == (len_q - (AW + 1)'(1)));

    // The table is frozen while a sequence runs, which also keeps m_tdata
    // stable through back-pressure.
    assign busy   = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign tbl_we = cfg_we & ~busy;

    adc_spi_seq_table #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_table (
        .aclk    (aclk),
        .aresetn (aresetn),
        .we      (tbl_we),
        .waddr   (cfg_addr),
        .wdata   (cfg_wdata),
        .raddr   (idx_q),
        .rdata   (rd_word)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= LEN_MAX;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        gap_d    = gap_q;
        m_tvalid = 1'b0;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    len_d   = len_sat;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                m_tvalid = 1'b1;
                if (m_tready) begin
                    if (last_word) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        gap_d   = '0;
                        state_d = (GAP_CYC == 0) ? ST_SEND : ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                // gap_q counts 0..GAP_CYC-1, giving exactly GAP_CYC idle cycles.
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    state_d = ST_SEND;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_tdata = m_tvalid ? rd_word : '0;

endmodule

// File: tb/tb_adc_spi_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_cmd_seq
// Directed + randomized bench for adc_spi_cmd_seq (WORD_W=16, DEPTH=4,
// GAP_CYC=10). A reference table and word-list model predict every output.
// -----------------------------------------------------------------------------
module tb_adc_spi_cmd_seq;

    localparam int WORD_W  = 16;
    localparam int DEPTH   = 4;
    localparam int GAP_CYC = 10;
    localparam int AW      = 2;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              start;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [WORD_W-1:0] cfg_wdata;
    logic [AW:0]       cfg_len;
    logic [WORD_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;
    logic [15:0] tbl_m [DEPTH];

    adc_spi_cmd_seq #(
        .WORD_W  (WORD_W),
        .DEPTH   (DEPTH),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (start),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_len   (cfg_len),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .busy      (busy),
        .done      (done)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tbl_m[0] = 16'h0100;
        tbl_m[1] = 16'h0201;
        tbl_m[2] = 16'h0302;
        tbl_m[3] = 16'h0400;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_data"},  32'(m_tdata),  32'd0);
        chk({tag, "_busy"},  32'(busy),     32'd0);
        chk({tag, "_done"},  32'(done),     32'd0);
    endtask

    task automatic cfg_write(input int addr, input logic [15:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(addr);
        cfg_wdata = data;
        @(negedge aclk);
        cfg_we    = 1'b0;
        tbl_m[addr] = data;
    endtask

    // Expected behaviour: the first L table words, one per handshake, the
    // word held while stalled, exactly GAP_CYC invalid cycles between words,
    // then one done cycle with busy low. Called at a negedge.
    task automatic run_seq(input int len_cfg, input bit do_start, input int ready_pct,
                           input int stall_w, input bit poke,
                           input bit wr, input int wr_addr, input logic [15:0] wr_data);
        int L;
        int sc;
        int waitc;
        bit rdy;
        logic [15:0] exp_q [$];
        if (wr) tbl_m[wr_addr] = wr_data;
        L = (len_cfg == 0 || len_cfg > DEPTH) ? DEPTH : len_cfg;
        exp_q = {};
        for (int i = 0; i < L; i++) exp_q.push_back(tbl_m[i]);
        if (do_start) begin
            start   = 1'b1;
            cfg_len = (AW + 1)'(len_cfg);
            if (wr) begin
                cfg_we    = 1'b1;
                cfg_addr  = AW'(wr_addr);
                cfg_wdata = wr_data;
            end
        end
        @(negedge aclk);
        start  = 1'b0;
        cfg_we = 1'b0;
        for (int w = 0; w < L; w++) begin
            sc    = 0;
            waitc = 0;
            rdy   = 1'b0;
            while (!rdy) begin
                chk($sformatf("w%0d_valid", w), 32'(m_tvalid), 32'd1);
                chk($sformatf("w%0d_data", w),  32'(m_tdata),  32'(exp_q[w]));
                chk($sformatf("w%0d_busy", w),  32'(busy),     32'd1);
                chk($sformatf("w%0d_done", w),  32'(done),     32'd0);
                start  = 1'b0;
                cfg_we = 1'b0;
                if (w == stall_w && sc < 5) begin
                    rdy = 1'b0;
                    sc++;
                end else begin
                    rdy = ($urandom_range(99) < ready_pct);
                end
                waitc++;
                if (waitc > 40) rdy = 1'b1;
                m_tready = rdy;
                @(negedge aclk);
            end
            m_tready = 1'($urandom_range(1));
            if (w < L - 1) begin
                for (int g = 0; g < GAP_CYC; g++) begin
                    chk($sformatf("gap%0d_%0d_valid", w, g), 32'(m_tvalid), 32'd0);
                    chk($sformatf("gap%0d_%0d_busy", w, g),  32'(busy),     32'd1);
                    chk($sformatf("gap%0d_%0d_done", w, g),  32'(done),     32'd0);
                    if (poke) begin
                        start     = 1'($urandom_range(1));
                        cfg_we    = 1'b1;
                        cfg_addr  = AW'($urandom_range(DEPTH - 1));
                        cfg_wdata = 16'($urandom);
                    end
                    @(negedge aclk);
                end
            end else begin
                chk("fin_done",  32'(done),     32'd1);
                chk("fin_busy",  32'(busy),     32'd0);
                chk("fin_valid", 32'(m_tvalid), 32'd0);
                start  = 1'b0;
                cfg_we = 1'b0;
                @(negedge aclk);
                chk("post_done",  32'(done),     32'd0);
                chk("post_busy",  32'(busy),     32'd0);
                chk("post_valid", 32'(m_tvalid), 32'd0);
            end
        end
        m_tready = 1'b1;
    endtask

    task automatic after_reset();
`ifdef ADC_SPI_SEQ_AUTOSTART_EN
        run_seq(DEPTH, 1'b0, 100, -1, 1'b0, 1'b0, 0, 16'h0);
`else
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("noauto%0d", i), 32'(m_tvalid), 32'd0);
            @(negedge aclk);
        end
`endif
    endtask

    initial begin
        aresetn   = 1'b0;
        start     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        cfg_len   = '0;
        m_tready  = 1'b1;
        model_reset();
        #1;
        chk_idle_outputs("rst");
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        after_reset();

        // Default four-word sequence, shifter always ready.
        run_seq(4, 1'b1, 100, -1, 1'b0, 1'b0, 0, 16'h0);
        // Five-cycle stall on the second word.
        run_seq(4, 1'b1, 100, 1, 1'b0, 1'b0, 0, 16'h0);
        // Idle write then a three-word sequence.
        cfg_write(2, 16'h03A5);
        run_seq(3, 1'b1, 100, -1, 1'b0, 1'b0, 0, 16'h0);
        // Write and start in the same cycle: new word goes out.
        run_seq(2, 1'b1, 100, -1, 1'b0, 1'b1, 1, 16'hBEEF);
        // start/cfg_we pokes while busy are ignored, table unchanged afterwards.
        run_seq(4, 1'b1, 70, -1, 1'b1, 1'b0, 0, 16'h0);
        run_seq(0, 1'b1, 100, -1, 1'b0, 1'b0, 0, 16'h0);
        // Randomized tables, lengths (incl. 0 and >DEPTH) and back-pressure.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 2; k++) cfg_write($urandom_range(DEPTH - 1), 16'($urandom));
            run_seq($urandom_range(7), 1'b1, $urandom_range(30, 100), -1,
                    1'($urandom_range(1)), 1'b0, 0, 16'h0);
        end

        // Reset during the gap after word 1 aborts and restores defaults.
        cfg_write(0, 16'h1234);
        start   = 1'b1;
        cfg_len = 3'd4;
        @(negedge aclk);
        start = 1'b0;
        chk("abort_w0_valid", 32'(m_tvalid), 32'd1);
        chk("abort_w0_data",  32'(m_tdata),  32'h1234);
        m_tready = 1'b1;
        @(negedge aclk);
        chk("abort_gap_valid", 32'(m_tvalid), 32'd0);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk_idle_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk($sformatf("abort_hold%0d", i), 32'(m_tvalid), 32'd0);
        end
        aresetn = 1'b1;
        model_reset();
        after_reset();
        run_seq(4, 1'b1, 100, -1, 1'b0, 1'b0, 0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_spi_cmd_seq.md
ADC_SPI_CMD_SEQ -- requirements
Module: adc_spi_cmd_seq

Interface
REQ-001 SHALL have parameter WORD_W, default 16, SPI command word width.
REQ-002 SHALL have parameter DEPTH, default 4, command table entries (power of two, 2..16).
REQ-003 SHALL have parameter GAP_CYC, default 10, minimum idle aclk cycles between words.
REQ-004 SHALL have port aclk  in  1  the single clock.
REQ-005 SHALL have port aresetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse launching a sequence.
REQ-007 SHALL have port cfg_we  in  1  table write strobe.
REQ-008 SHALL have port cfg_addr  in  $clog2(DEPTH)  table write index.
REQ-009 SHALL have port cfg_wdata  in  WORD_W  table write data.
REQ-010 SHALL have port cfg_len  in  $clog2(DEPTH)+1  words per sequence (0 treated as DEPTH).
REQ-011 SHALL have port m_tdata  out  WORD_W  command word to the downstream SPI shifter.
REQ-012 SHALL have port m_tvalid  out  1  m_tdata valid.
REQ-013 SHALL have port m_tready  in  1  shifter accepts word.
REQ-014 SHALL have port busy  out  1  sequence in progress.
REQ-015 SHALL have port done  out  1  one-cycle pulse after last word accepted.

Function
REQ-016 SHALL implement states IDLE, SEND, GAP, FIN.
REQ-017 IDLE: start=1 SHALL latch cfg_len, clear index, go to SEND next cycle; busy=1 from that cycle.
REQ-018 SEND: m_tvalid=1, m_tdata=table[index]; handshake = m_tvalid&m_tready on rising aclk.
REQ-019 On handshake, if index==len-1 SHALL go FIN, else index+1 and go GAP.
REQ-020 GAP SHALL hold m_tvalid=0 for exactly GAP_CYC cycles, then SEND.
REQ-021 FIN SHALL assert done for one cycle, clear busy, return to IDLE.
REQ-022 m_tdata and m_tvalid SHALL stay stable while m_tvalid=1 and m_tready=0 (AXI-Stream rule).
REQ-023 start while busy SHALL be ignored (no restart, no queueing).
REQ-024 cfg_we while busy SHALL be ignored; while idle it writes in the same cycle; write and start in one cycle: write lands first and is sent.
REQ-025 Latency: start pulse to first m_tvalid SHALL be 1 cycle; last handshake to done SHALL be 1 cycle.
REQ-026 cfg_len > DEPTH SHALL saturate to DEPTH.

Reset
REQ-027 aresetn low SHALL force IDLE asynchronously; m_tvalid=0, m_tdata=0, busy=0, done=0, index=0.
REQ-028 Reset SHALL load table entries 0..3 with 16'h0100, 16'h0201, 16'h0302, 16'h0400; remaining entries 0.
REQ-029 Reset mid-sequence SHALL abort without emitting further words; table reverts to defaults.

Configuration
REQ-030 With ADC_SPI_SEQ_AUTOSTART_EN defined, SHALL internally generate one start pulse on the first aclk after aresetn deasserts, with len=DEPTH.
REQ-031 Without ADC_SPI_SEQ_AUTOSTART_EN, sequences SHALL start only from the start port.

Structure
REQ-032 Package adc_spi_seq_pkg SHALL hold the state enum, WORD_W default and the default-table constant.
REQ-033 Table storage SHALL be sub-module adc_spi_seq_table (register array, async-reset to defaults, single write port, combinational read).

Verification
REQ-034 Reset release, start pulse, m_tready=1 -> m_tdata 0100,0201,0302,0400, each followed by 10 idle cycles, one done pulse.
REQ-035 m_tready low 5 cycles during word 2 -> m_tdata=0201 held stable, no word lost or duplicated.
REQ-036 Idle write addr 2 = 16'h03A5, cfg_len=3, start -> words 0100,0201,03A5 then done.
REQ-037 start and cfg_we pulses while busy -> sequence unchanged, no restart, table unchanged.
REQ-038 aresetn low during GAP after word 1 -> outputs zero immediately; no further words; table defaults restored.
REQ-039 ADC_SPI_SEQ_AUTOSTART_EN defined, no start pulse -> default 4-word sequence emitted after reset.
